// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the VGA/XGA raster timing generator.
package vga_timing_pkg;

    // XGA 1024x768 defaults
    localparam int   DEF_CNT_W    = 11;
    localparam int   DEF_H_ACTIVE = 1024;
    localparam int   DEF_H_FP     = 24;
    localparam int   DEF_H_SYNC   = 136;
    localparam int   DEF_H_BP     = 144;
    localparam int   DEF_V_ACTIVE = 768;
    localparam int   DEF_V_FP     = 3;
    localparam int   DEF_V_SYNC   = 6;
    localparam int   DEF_V_BP     = 29;
    localparam logic DEF_HS_POL   = 1'b1;
    localparam logic DEF_VS_POL   = 1'b1;

    // Total period of one axis (pixels per line or lines per frame).
    function automatic int tot(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with registered blank and sync decodes.
// The wrap strobe is combinational so the next axis can advance on the same edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W  = DEF_CNT_W,
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter logic POL    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             blank,
    output logic             blank_nxt,
    output logic             sync,
    output logic             wrap
);

    localparam int               TOT         = tot(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOT - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_STOP   = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic [CNT_W-1:0] count_d, count_q;
    logic             blank_d, blank_q;
    logic             sync_d,  sync_q;

    // Next count and its decodes; registering the decodes keeps them aligned with count.
    // NOTE: every variable gets a value before any branch, so no path can infer a latch.
    always_comb begin
        wrap    = adv && (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (adv) begin
            count_d = count_q + CNT_W'(1);
        end
        blank_d = (count_d >= BLANK_START);
        sync_d  = ((count_d >= SYNC_START) && (count_d <= SYNC_STOP)) ? POL : ~POL;
    end

    // State update; reset lands on count 0, which is visible and outside sync.
    // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~POL;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count     = count_q;
    assign blank     = blank_q;
    assign blank_nxt = blank_d;
    assign sync      = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/XGA raster timing generator: counters, blanking, sync, data enable
// and line/frame start pulses, all registered together. en=0 freezes the raster.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W    = DEF_CNT_W,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = DEF_HS_POL,
    parameter logic VS_POL   = DEF_VS_POL
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Reject degenerate timings and totals the counters cannot represent.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_timing
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end
    if (clog2(H_TOT) > CNT_W) begin : g_h_too_wide
        $error("vga_timing_gen: H_TOT %0d does not fit in CNT_W=%0d bits", H_TOT, CNT_W);
    end
    if (clog2(V_TOT) > CNT_W) begin : g_v_too_wide
        $error("vga_timing_gen: V_TOT %0d does not fit in CNT_W=%0d bits", V_TOT, CNT_W);
    end

    logic h_wrap, v_wrap, v_adv;
    logic h_blank_nxt, v_blank_nxt;

    // Lines advance only when the pixel counter wraps during an enabled cycle.
    assign v_adv = h_wrap & en;

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (HS_POL)
    ) u_h_axis (
        .clk      (pclk),
        .rst      (rst),
        .adv      (en),
        .count    (hcount),
        .blank    (hblnk),
        .blank_nxt(h_blank_nxt),
        .sync     (hsync),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (VS_POL)
    ) u_v_axis (
        .clk      (pclk),
        .rst      (rst),
        .adv      (v_adv),
        .count    (vcount),
        .blank    (vblnk),
        .blank_nxt(v_blank_nxt),
        .sync     (vsync),
        .wrap     (v_wrap)
    );

    logic de_d, de_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    // Data enable from next-state blanks; pulses from this cycle's wraps (both gated by en).
    always_comb begin
        de_d          = ~h_blank_nxt & ~v_blank_nxt;
        line_start_d  = h_wrap;
        frame_start_d = h_wrap & v_wrap;
    end

    // Register the top-level outputs alongside the axis counters.
    always_ff @(posedge pclk) begin
        if (rst) begin
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations (XGA defaults, a tiny
// negative-polarity mode, and a short-line mode with XGA vertical timing).
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hb, vb, hs, vs, de, ls, fs;
    } obs_t;

    typedef struct packed {
        logic [1:0] sel;
        obs_t       o;
    } exp_t;

    // Tiny mode decode tables (bit index = hcount / vcount), hand-derived.
    localparam bit [11:0] SM_HB = 12'b1111_0000_0000;  // hcount >= 8
    localparam bit [11:0] SM_HS = 12'b1001_1111_1111;  // low at 9..10
    localparam bit [6:0]  SM_VB = 7'b111_0000;         // vcount >= 4
    localparam bit [6:0]  SM_VS = 7'b101_1111;         // low at 5

    logic       pclk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [2:0] en_v  = 3'b000;

    always #5 pclk = ~pclk;

    logic [10:0] hc0, vc0, hc2, vc2;
    logic [3:0]  hc1, vc1;
    logic hb0, vb0, hs0, vs0, de0, ls0, fs0;
    logic hb1, vb1, hs1, vs1, de1, ls1, fs1;
    logic hb2, vb2, hs2, vs2, de2, ls2, fs2;

    vga_timing_gen u_xga (
        .pclk(pclk), .rst(rst_v[0]), .en(en_v[0]),
        .hcount(hc0), .vcount(vc0), .hblnk(hb0), .vblnk(vb0),
        .hsync(hs0), .vsync(vs0), .de(de0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CNT_W(4), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_small (
        .pclk(pclk), .rst(rst_v[1]), .en(en_v[1]),
        .hcount(hc1), .vcount(vc1), .hblnk(hb1), .vblnk(vb1),
        .hsync(hs1), .vsync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4)
    ) u_short (
        .pclk(pclk), .rst(rst_v[2]), .en(en_v[2]),
        .hcount(hc2), .vcount(vc2), .hblnk(hb2), .vblnk(vb2),
        .hsync(hs2), .vsync(vs2), .de(de2), .line_start(ls2), .frame_start(fs2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int h_tot(input int s);
        case (s)
            0:       return 1328;
            1:       return 12;
            default: return 32;
        endcase
    endfunction

    function automatic int v_tot(input int s);
        return (s == 1) ? 7 : 806;
    endfunction

    function automatic obs_t model_obs(input int s, input int h, input int v, input bit ls, input bit fs);
        obs_t o;
        o.hc = 11'(h);
        o.vc = 11'(v);
        o.ls = ls;
        o.fs = fs;
        case (s)
            0: begin
                o.hb = (h >= 1024);
                o.hs = (h >= 1048) && (h <= 1183);
                o.vb = (v >= 768);
                o.vs = (v >= 771) && (v <= 776);
            end
            1: begin
                o.hb = SM_HB[h];
                o.hs = SM_HS[h];
                o.vb = SM_VB[v];
                o.vs = SM_VS[v];
            end
            default: begin
                o.hb = (h >= 16);
                o.hs = (h >= 20) && (h <= 27);
                o.vb = (v >= 768);
                o.vs = (v >= 771) && (v <= 776);
            end
        endcase
        o.de = !o.hb && !o.vb;
        return o;
    endfunction

    exp_t q[$];
    int   m_h[3];
    int   m_v[3];

    // Apply one cycle of stimulus to configuration s and queue the expected outputs.
    task automatic drive(input int s, input logic r, input logic e);
        exp_t x;
        bit   ls, fs;
        @(negedge pclk);
        rst_v[s] = r;
        en_v[s]  = e;
        ls = 1'b0;
        fs = 1'b0;
        if (r) begin
            m_h[s] = 0;
            m_v[s] = 0;
        end else if (e) begin
            if (m_h[s] == h_tot(s) - 1) begin
                ls = 1'b1;
                m_h[s] = 0;
                if (m_v[s] == v_tot(s) - 1) begin
                    fs = 1'b1;
                    m_v[s] = 0;
                end else begin
                    m_v[s]++;
                end
            end else begin
                m_h[s]++;
            end
        end
        x.sel = 2'(s);
        x.o   = model_obs(s, m_h[s], m_v[s], ls, fs);
        q.push_back(x);
    endtask

    task automatic settle();
        @(posedge pclk);
        #2;
    endtask

    // ---------------- monitor ----------------
    function automatic obs_t dut_obs(input int s);
        obs_t o;
        case (s)
            0:       o = {hc0, vc0, hb0, vb0, hs0, vs0, de0, ls0, fs0};
            1:       o = {7'd0, hc1, 7'd0, vc1, hb1, vb1, hs1, vs1, de1, ls1, fs1};
            default: o = {hc2, vc2, hb2, vb2, hs2, vs2, de2, ls2, fs2};
        endcase
        return o;
    endfunction

    obs_t prev[3];
    int   ls_cnt[3];
    int   fs_cnt[3];
    int   h_wrap_from[3];
    int   v_wrap_from[3];
    int   hs_rise0 = -1, hs_fall0 = -1, hb_rise0 = -1;
    int   vs_rise2 = -1, vs_fall2 = -1, vb_rise2 = -1, vs_edge_hc2 = -1;

    initial begin
        forever begin
            @(posedge pclk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                obs_t a;
                int   s;
                e = q.pop_front();
                s = int'(e.sel);
                a = dut_obs(s);
                check($sformatf("cfg%0d outputs at h=%0d v=%0d", s, e.o.hc, e.o.vc), 64'(a), 64'(e.o));
                if (a.ls) begin
                    ls_cnt[s]++;
                    h_wrap_from[s] = int'(prev[s].hc);
                end
                if (a.fs) begin
                    fs_cnt[s]++;
                    v_wrap_from[s] = int'(prev[s].vc);
                end
                if (s == 0) begin
                    if (a.hs && !prev[0].hs) hs_rise0 = int'(a.hc);
                    if (!a.hs && prev[0].hs) hs_fall0 = int'(a.hc);
                    if (a.hb && !prev[0].hb) hb_rise0 = int'(a.hc);
                end
                if (s == 2) begin
                    if (a.vs !== prev[2].vs && prev[2].vs !== 1'bx) begin
                        vs_edge_hc2 = int'(a.hc);
                        if (a.vs) vs_rise2 = int'(a.vc);
                        else      vs_fall2 = int'(a.vc);
                    end
                    if (a.vb && prev[2].vb === 1'b0) vb_rise2 = int'(a.vc);
                end
                prev[s] = a;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ls_s, fs_s;
        repeat (3) @(posedge pclk);

        // XGA defaults: reset with en high, then a little over one line.
        drive(0, 1'b1, 1'b1);
        repeat (1400) drive(0, 1'b0, 1'b1);
        settle();
        check("xga hsync rises at hcount", 64'(hs_rise0), 64'(1048));
        check("xga hsync falls at hcount", 64'(hs_fall0), 64'(1184));
        check("xga hblnk rises at hcount", 64'(hb_rise0), 64'(1024));
        check("xga hcount wraps from", 64'(h_wrap_from[0]), 64'(1327));
        check("xga line_start count", 64'(ls_cnt[0]), 64'(1));
        // Pause mid-line, then reset with en low; no frame_start may follow.
        while (m_h[0] != 500) drive(0, 1'b0, 1'b1);
        repeat (2) drive(0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0);
        repeat (20) drive(0, 1'b0, 1'b1);
        settle();
        check("xga frame_start after reset", 64'(fs_cnt[0]), 64'(0));
        en_v[0] = 1'b0;

        // Short lines with XGA vertical timing: one full frame, freeze at the last pixel.
        drive(2, 1'b1, 1'b0);
        while (!(m_h[2] == 31 && m_v[2] == 805)) drive(2, 1'b0, 1'b1);
        repeat (10) drive(2, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b1);
        settle();
        check("short line_start per frame", 64'(ls_cnt[2]), 64'(806));
        check("short frame_start per frame", 64'(fs_cnt[2]), 64'(1));
        check("short vcount wraps from", 64'(v_wrap_from[2]), 64'(805));
        check("short hcount wraps from", 64'(h_wrap_from[2]), 64'(31));
        check("short vsync rises at vcount", 64'(vs_rise2), 64'(771));
        check("short vsync falls at vcount", 64'(vs_fall2), 64'(777));
        check("short vsync edge hcount", 64'(vs_edge_hc2), 64'(0));
        check("short vblnk rises at vcount", 64'(vb_rise2), 64'(768));
        en_v[2] = 1'b0;

        // Tiny negative-polarity mode: two frames, freeze at the wrap, mid-frame reset.
        drive(1, 1'b1, 1'b0);
        settle();
        for (int f = 0; f < 2; f++) begin
            ls_s = ls_cnt[1];
            fs_s = fs_cnt[1];
            repeat (84) drive(1, 1'b0, 1'b1);
            settle();
            check($sformatf("small frame %0d line_start", f), 64'(ls_cnt[1] - ls_s), 64'(7));
            check($sformatf("small frame %0d frame_start", f), 64'(fs_cnt[1] - fs_s), 64'(1));
        end
        check("small hcount wraps from", 64'(h_wrap_from[1]), 64'(11));
        check("small vcount wraps from", 64'(v_wrap_from[1]), 64'(6));
        fs_s = fs_cnt[1];
        repeat (83) drive(1, 1'b0, 1'b1);
        repeat (10) drive(1, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b1);
        settle();
        check("small frame_start after freeze", 64'(fs_cnt[1] - fs_s), 64'(1));
        repeat (41) drive(1, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0);
        settle();
        fs_s = fs_cnt[1];
        repeat (83) drive(1, 1'b0, 1'b1);
        settle();
        check("small frame_start before first wrap", 64'(fs_cnt[1] - fs_s), 64'(0));
        drive(1, 1'b0, 1'b1);
        settle();
        check("small frame_start at first wrap", 64'(fs_cnt[1] - fs_s), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/XGA raster timing generator: the successor to the fixed 1024x768 timing block. It produces pixel and line counters, blanking, polarity-configurable sync and data-enable, plus one-cycle line and frame start pulses. A run/pause input `en` freezes the raster. The block sits at the head of the video pipeline in the `pclk` domain and feeds the drawing and pixel-mux stages.

## Interface
- `CNT_W`, 11, width of `hcount` and `vcount`.
- `H_ACTIVE`, 1024, visible pixels per line.
- `H_FP`, 24, horizontal front porch, in pixels.
- `H_SYNC`, 136, horizontal sync width, in pixels.
- `H_BP`, 144, horizontal back porch, in pixels.
- `V_ACTIVE`, 768, visible lines per frame.
- `V_FP`, 3, vertical front porch, in lines.
- `V_SYNC`, 6, vertical sync width, in lines.
- `V_BP`, 29, vertical back porch, in lines.
- `HS_POL`, 1, active level of `hsync` (1 = active-high).
- `VS_POL`, 1, active level of `vsync` (1 = active-high).

Ports:
- `pclk`  in  1  pixel clock. This is the only clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  raster advance enable. When low, all outputs hold their current values.
- `hcount`  out  CNT_W  pixel index, 0..H_TOT-1.
- `vcount`  out  CNT_W  line index, 0..V_TOT-1.
- `hblnk`, `vblnk`  out  1  horizontal and vertical blanking.
- `hsync`, `vsync`  out  1  sync outputs, at the polarity set by `HS_POL` / `VS_POL`.
- `de`  out  1  data enable, equal to `!hblnk && !vblnk`.
- `line_start`  out  1  one-cycle pulse when `hcount` becomes 0 after a wrap.
- `frame_start`  out  1  one-cycle pulse when (`hcount`,`vcount`) becomes (0,0) after a wrap.

## Operation
- Derived totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. The defaults give H_TOT = 1328 and V_TOT = 806.
- Elaboration fails if any timing parameter is 0, or if H_TOT > 2^CNT_W or V_TOT > 2^CNT_W.
- Counting with `en`=1:
  - `hcount` increments by 1 each cycle.
  - At H_TOT-1, `hcount` wraps to 0 and `vcount` increments.
  - At (H_TOT-1, V_TOT-1), both counters wrap to 0.
- With `en`=0: counters, blanking, sync and `de` hold. `line_start` and `frame_start` are 0 on the next cycle.
- Decode:
  - `hblnk` = (`hcount` >= H_ACTIVE).
  - `vblnk` = (`vcount` >= V_ACTIVE).
  - `hsync` is active for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - `vsync` is active for `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] and toggles only at `hcount`=0.
- All decodes are computed from the next-state counter values and registered. Every output is therefore cycle-aligned with the registered `hcount`/`vcount`, with zero skew.
- Pulses:
  - `line_start`=1 only in the cycle after an advance that wrapped `hcount`.
  - `frame_start`=1 only in the cycle after an advance that wrapped both counters. It implies `line_start`=1.
- Counter arithmetic is unsigned, CNT_W bits wide, with no saturation.

## Timing
- Reset values:
  - `hcount`=0, `vcount`=0, `hblnk`=0, `vblnk`=0, `de`=1.
  - `hsync`=!HS_POL, `vsync`=!VS_POL.
  - `line_start`=0, `frame_start`=0.
- The first frame after reset is not flagged by `frame_start`; the first pulse comes at the first (0,0) wrap.
- `rst` asserted mid-frame forces the reset values on the next edge, regardless of `en`.
- Output latency from state: 0 cycles, because all outputs are registered together.
- `en` takes effect on the same edge it is sampled: if `en`=0 at edge k, the outputs after edge k equal those before it.
- Simultaneous wrap and `en`=0: the wrap does not occur and no pulse is produced. The wrap happens on the next edge with `en`=1.
- Default-parameter landmarks:
  - `hblnk` rises at `hcount`=1024.
  - `hsync` is active for `hcount` 1048..1183.
  - `vblnk` is asserted for `vcount` 768..805.
  - `vsync` is active for `vcount` 771..776.

## Structure
- Package `vga_timing_pkg`:
  - default XGA constants (the eleven parameter defaults);
  - function `tot(active,fp,sync,bp)`;
  - function `clog2` for width checks.
- Sub-module `vga_axis_counter`, instanced twice (horizontal and vertical). It has parameters ACTIVE/FP/SYNC/BP/POL/CNT_W and an advance input.
  - It outputs the registered count, blank, sync and a wrap strobe.
  - The vertical instance advances on the horizontal wrap strobe ANDed with `en`.
- The top level generates `de`, `line_start` and `frame_start` and holds the parameter checks.

## Test plan
- Reset, then `en`=1 with defaults for 2 full frames. Check:
  - `hcount` wraps 1327->0 and `vcount` wraps 805->0;
  - exactly one `frame_start` per frame, at (0,0);
  - 806 `line_start` pulses per frame.
- Defaults, one line: `hsync` goes high at `hcount`=1048 and low at 1184; `hblnk` is high over 1024..1327; `de` is low whenever `vcount` >= 768.
- `en`=0 for 10 cycles at (1327,805): all outputs frozen and no pulse. When `en` returns to 1, the next edge gives (0,0) with `frame_start`=1.
- Assert `rst` for 1 cycle at (500,400) with `en`=0. Check the exact reset values listed under Timing, and that `frame_start` stays 0 until the first wrap.
- Small mode: H=8/1/2/1, V=4/1/1/1, HS_POL=0, VS_POL=0, CNT_W=4. Check:
  - H_TOT=12, V_TOT=7;
  - `hsync` low only at `hcount` 9..10;
  - `vsync` low only at `vcount` 5.
- CNT_W=10 with defaults: elaboration error, because H_TOT = 1328 > 1024.
